// File: rtl/fb_scanout_pkg.sv
// Shared VGA 640x480@60 timing constants and RGB565 field positions for the
// framebuffer scanout path.
package fb_scanout_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

  // RD_LATENCY must stay below CLK_DIV so fb_data settles before the next pixel tick.
  localparam int CLK_DIV    = 4;
  localparam int RD_LATENCY = 1;

  localparam int H_W    = 10;
  localparam int V_W    = 10;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 16;
  localparam int CH_W   = 4;

  // Top CH_W bits of each RGB565 field.
  localparam int R_MSB = 15;
  localparam int G_MSB = 10;
  localparam int B_MSB = 4;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb444_t;

endpackage

// File: rtl/fb_scanout_timing.sv
// Pixel-rate divider plus horizontal/vertical fetch counters; all status
// outputs are decoded from the registered counters.
module vga_timing
  import fb_scanout_pkg::*;
#(
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  output logic           o_pix_en,
  output logic [H_W-1:0] o_h,
  output logic [V_W-1:0] o_v,
  output logic           o_active,
  output logic           o_hs,
  output logic           o_vs,
  output logic           o_in_vblank
);

  localparam int VT    = P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP;
  localparam int VS0   = P_V_ACTIVE + P_V_FP;
  localparam int VS1   = VS0 + P_V_SYNC - 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] r_div;
  logic [H_W-1:0]   r_h;
  logic [V_W-1:0]   r_v;
  logic             w_pix_en;
  logic             w_h_last;
  logic             w_v_last;

  assign w_pix_en = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_h_last = (r_h == H_W'(H_TOTAL - 1));
  assign w_v_last = (r_v == V_W'(VT - 1));

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= w_pix_en ? '0 : r_div + 1'b1;
      if (w_pix_en) begin
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? '0 : r_v + 1'b1;
        end else begin
          r_h <= r_h + 1'b1;
        end
      end
    end
  end

  assign o_pix_en    = w_pix_en;
  assign o_h         = r_h;
  assign o_v         = r_v;
  assign o_active    = (r_h < H_W'(H_ACTIVE)) && (r_v < V_W'(P_V_ACTIVE));
  assign o_hs        = !((r_h >= H_W'(H_SYNC_START)) && (r_h <= H_W'(H_SYNC_END)));
  assign o_vs        = !((r_v >= V_W'(VS0)) && (r_v <= V_W'(VS1)));
  assign o_in_vblank = (r_v >= V_W'(P_V_ACTIVE));

endmodule

// File: rtl/fb_scanout.sv
// Framebuffer scanout: address generation from the fetch counters, one pixel
// period of output registering for rgb/sync, and the frame_done pulse.
module fb_scanout
  import fb_scanout_pkg::*;
#(
  parameter int P_V_ACTIVE = V_ACTIVE,
  parameter int P_V_FP     = V_FP,
  parameter int P_V_SYNC   = V_SYNC,
  parameter int P_V_BP     = V_BP
) (
  input  logic              clk,
  input  logic              rstn,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [PIX_W-1:0]  fb_data,
  output logic [CH_W-1:0]   vga_r,
  output logic [CH_W-1:0]   vga_g,
  output logic [CH_W-1:0]   vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              frame_done,
  output logic              in_vblank
);

  logic           w_pix_en;
  logic [H_W-1:0] w_h;
  logic [V_W-1:0] w_v;
  logic           w_active;
  logic           w_hs;
  logic           w_vs;
  logic           w_in_vblank;

  vga_timing #(
    .P_V_ACTIVE (P_V_ACTIVE),
    .P_V_FP     (P_V_FP),
    .P_V_SYNC   (P_V_SYNC),
    .P_V_BP     (P_V_BP)
  ) u_timing (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .o_pix_en    (w_pix_en),
    .o_h         (w_h),
    .o_v         (w_v),
    .o_active    (w_active),
    .o_hs        (w_hs),
    .o_vs        (w_vs),
    .o_in_vblank (w_in_vblank)
  );

  // Row base v*640 built as v*512 + v*128 so no multiplier is inferred.
  logic [ADDR_W-1:0] w_v_ext;
  logic [ADDR_W-1:0] w_row_base;

  assign w_v_ext    = ADDR_W'(w_v);
  assign w_row_base = (w_v_ext << 9) + (w_v_ext << 7);
  assign fb_addr    = w_active ? (w_row_base + ADDR_W'(w_h)) : '0;

  // The RGB565 LSBs below each 4-bit channel are intentionally dropped.
  logic w_unused_px;
  assign w_unused_px = ^{fb_data[11], fb_data[6:5], fb_data[0]};

  rgb444_t r_rgb;
  logic    r_hs_d1;
  logic    r_vs_d1;
  logic    r_frame_done;
  logic    w_frame_end;

  assign w_frame_end = w_pix_en && (w_h == H_W'(H_TOTAL - 1)) &&
                       (w_v == V_W'(P_V_ACTIVE - 1));

  // At each pixel tick the counters still hold the pixel whose data is on
  // fb_data, so gating with the current active flag keeps rgb and sync aligned.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rgb        <= '0;
      r_hs_d1      <= 1'b1;
      r_vs_d1      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_frame_end;
      if (w_pix_en) begin
        r_hs_d1 <= w_hs;
        r_vs_d1 <= w_vs;
        if (w_active) begin
          r_rgb.r <= fb_data[R_MSB -: CH_W];
          r_rgb.g <= fb_data[G_MSB -: CH_W];
          r_rgb.b <= fb_data[B_MSB -: CH_W];
        end else begin
          r_rgb <= '0;
        end
      end
    end
  end

  assign vga_r      = r_rgb.r;
  assign vga_g      = r_rgb.g;
  assign vga_b      = r_rgb.b;
  assign vga_hs     = r_hs_d1;
  assign vga_vs     = r_vs_d1;
  assign frame_done = r_frame_done;
  assign in_vblank  = w_in_vblank;

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout with a shortened vertical frame: arithmetic pixel-index
// model checked every clk, plus hand-computed literal expectations.
`timescale 1ns/1ps
module tb_fb_scanout;

  localparam int VA  = 4;
  localparam int VFP = 2;
  localparam int VSY = 2;
  localparam int VBP = 1;
  localparam int VT  = VA + VFP + VSY + VBP;
  localparam int HT  = 800;
  localparam int FT  = HT * VT;

  // clock / reset
  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic [18:0] fb_addr;
  logic [15:0] fb_data = 16'h0;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs, frame_done, in_vblank;

  fb_scanout #(
    .P_V_ACTIVE (VA),
    .P_V_FP     (VFP),
    .P_V_SYNC   (VSY),
    .P_V_BP     (VBP)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .vga_hs     (vga_hs),
    .vga_vs     (vga_vs),
    .frame_done (frame_done),
    .in_vblank  (in_vblank)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // mode < 0: memory returns an address-derived pattern; otherwise a constant.
  int mode   = 32'hFFFF;
  int mode_p = 32'hFFFF;

  function automatic logic [15:0] memfn(input int m, input logic [18:0] a);
    logic [15:0] c;
    if (m < 0) return ~a[15:0] ^ {a[8:0], 7'b0};
    c = m[15:0];
    return c;
  endfunction

  // one-cycle-latency framebuffer RAM
  always @(posedge clk) fb_data <= memfn(mode, fb_addr);

  // clocks since reset release
  int cyc = 0;
  always @(posedge clk or negedge rstn)
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;

  // model: pixel index n = cyc/4; counters show pixel n, outputs show pixel n-1
  int m_n, m_s, m_h, m_v, m_p, m_hp, m_vp;
  logic [18:0] m_ea, m_pa;
  logic [15:0] m_d;
  logic [11:0] m_rgb;
  logic        m_hs, m_vs, m_fd, m_vb;

  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_addr", fb_addr, 0);
      chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
      chk("rst_hs", vga_hs, 1);
      chk("rst_vs", vga_vs, 1);
      chk("rst_fd", frame_done, 0);
      chk("rst_vblank", in_vblank, 0);
    end else begin
      if (cyc % 4 == 0) mode_p = mode;
      m_n  = cyc / 4;
      m_s  = m_n % FT;
      m_h  = m_s % HT;
      m_v  = m_s / HT;
      m_ea = (m_h < 640 && m_v < VA) ? 19'(m_v * 640 + m_h) : 19'd0;
      m_vb = (m_v >= VA);
      m_fd = (cyc % 4 == 0) && (m_n >= 1) && (m_h == 0) && (m_v == VA);
      if (m_n == 0) begin
        m_rgb = 12'h0;
        m_hs  = 1'b1;
        m_vs  = 1'b1;
      end else begin
        m_p  = (m_n - 1) % FT;
        m_hp = m_p % HT;
        m_vp = m_p / HT;
        m_hs = !(m_hp >= 656 && m_hp <= 751);
        m_vs = !(m_vp >= VA + VFP && m_vp < VA + VFP + VSY);
        if (m_hp < 640 && m_vp < VA) begin
          m_pa  = 19'(m_vp * 640 + m_hp);
          m_d   = memfn(mode_p, m_pa);
          m_rgb = {m_d[15:12], m_d[10:7], m_d[4:1]};
        end else begin
          m_rgb = 12'h0;
        end
      end
      chk("addr", fb_addr, m_ea);
      chk("rgb", {vga_r, vga_g, vga_b}, m_rgb);
      chk("hs", vga_hs, m_hs);
      chk("vs", vga_vs, m_vs);
      chk("frame_done", frame_done, m_fd);
      chk("in_vblank", in_vblank, m_vb);
    end
  end

  // event monitors
  int hs_fall   = -1;
  int hs_low0   = 0;
  int vs_low0   = 0;
  int max_addr0 = 0;
  int fd_high   = 0;
  logic prev_hs = 1'b1;
  logic prev_vb = 1'b0;
  int fd_q[$];
  int vb_q[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (prev_hs && !vga_hs && hs_fall < 0) hs_fall = cyc;
      if (!vga_hs && cyc < 3200) hs_low0++;
      if (!vga_vs && cyc < 28800) vs_low0++;
      if (cyc < 28800 && int'(fb_addr) > max_addr0) max_addr0 = int'(fb_addr);
      if (frame_done) begin
        fd_high++;
        fd_q.push_back(cyc);
      end
      if (in_vblank && !prev_vb) vb_q.push_back(cyc);
      prev_hs = vga_hs;
      prev_vb = in_vblank;
    end
  end

  // driver tasks
  task automatic wait_cyc(input int c);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < c && guard < 100000);
    chk("wait_cyc", cyc, c);
  endtask

  task automatic set_mode(input int m);
    #1 mode = m;
  endtask

  initial begin
    #1_500_000;
    errors++;
    $display("FAIL watchdog expired checks=%0d", checks);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    rstn = 1'b0;
    mode = 32'hFFFF;
    repeat (3) @(negedge clk);
    chk("lit_rst_addr", fb_addr, 0);
    chk("lit_rst_hsvs", {vga_hs, vga_vs}, 2'b11);
    rstn = 1'b1;

    wait_cyc(3);
    chk("lit_addr_c3", fb_addr, 0);
    chk("lit_rgb_c3", {vga_r, vga_g, vga_b}, 12'h000);
    wait_cyc(4);
    chk("lit_addr_c4", fb_addr, 1);
    chk("lit_rgb_first", {vga_r, vga_g, vga_b}, 12'hFFF);
    wait_cyc(8);
    chk("lit_addr_c8", fb_addr, 2);
    set_mode(-1);

    wait_cyc(400);
    chk("lit_addr_c400", fb_addr, 100);
    chk("lit_rgb_pat99", {vga_r, vga_g, vga_b}, 12'hCCE);

    wait_cyc(3204);
    set_mode(32'hF800);
    wait_cyc(3208);
    chk("lit_red", {vga_r, vga_g, vga_b}, 12'hF00);
    set_mode(32'h07E0);
    wait_cyc(3212);
    chk("lit_green", {vga_r, vga_g, vga_b}, 12'h0F0);
    set_mode(32'hFFFF);

    wait_cyc(6000);
    chk("lit_blank_forced", {vga_r, vga_g, vga_b}, 12'h000);
    chk("lit_hs_fall", hs_fall, 2628);
    chk("lit_hs_width", hs_low0, 384);
    set_mode(-1);

    wait_cyc(30000);
    chk("lit_vs_width", vs_low0, 6400);
    chk("lit_max_addr", max_addr0, 2559);
    chk("lit_fd_count1", fd_q.size(), 1);
    if (fd_q.size() >= 1) chk("lit_fd_first", fd_q[0], 12800);
    if (vb_q.size() >= 1) chk("lit_vb_rise", vb_q[0], 12800);

    wait_cyc(41604);
    chk("lit_fd_count2", fd_q.size(), 2);
    chk("lit_fd_width", fd_high, 2);
    if (fd_q.size() >= 2) chk("lit_frame_period", fd_q[1] - fd_q[0], 28800);

    wait_cyc(65201);
    chk("lit_addr_mid", fb_addr, 1580);
    #1 rstn = 1'b0;
    #1;
    chk("lit_midrst_addr", fb_addr, 0);
    chk("lit_midrst_rgb", {vga_r, vga_g, vga_b}, 12'h000);
    chk("lit_midrst_sync", {vga_hs, vga_vs}, 2'b11);
    chk("lit_midrst_flags", {frame_done, in_vblank}, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    fd_q.delete();
    rstn = 1'b1;

    wait_cyc(12804);
    chk("lit_fd_after_rst_n", fd_q.size(), 1);
    if (fd_q.size() >= 1) chk("lit_fd_after_rst", fd_q[0], 12800);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
